// File: rtl/vga_pkg.sv
// Shared VGA definitions: screen geometry, interrupt-handler state encoding
// and default counter widths.
package vga_pkg;

  localparam int VGA_WIDTH   = 640;
  localparam int VGA_HEIGHT  = 480;

  localparam int FRAME_CNT_W = 16;
  localparam int OVR_CNT_W   = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    PENDING = ST_PENDING,
    SERVICE = ST_SERVICE
  } irq_state_e;

  // Even parity over the state word, for downstream integrity monitors.
  function automatic logic state_parity(input logic [1:0] st);
    return ^st;
  endfunction

endpackage

// File: rtl/vga_irq_handler_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment in the
// same cycle restart the count at one.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;
  logic [W-1:0] count_next_s;

  // Next count: clear has priority over hold, increment stops at all-ones.
  always_comb begin
    count_next_s = count_r;
    if (clr && inc) begin
      count_next_s = {{(W-1){1'b0}}, 1'b1};
    end else if (clr) begin
      count_next_s = {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_next_s = count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else begin
      count_r <= count_next_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/vga_irq_handler.sv
// End-of-frame interrupt consumer: turns the one-cycle VGA pulse into a level
// IRQ with ack/done handshake, counts frames and tracks dropped (overrun) frames.
module vga_irq_handler
  import vga_pkg::*;
#(
  parameter int FRAME_CNT_W = vga_pkg::FRAME_CNT_W,
  parameter int OVR_CNT_W   = vga_pkg::OVR_CNT_W
) (
  input  logic                   pixel_clock,
  input  logic                   rst,
  input  logic                   interrupt_in,
  input  logic                   irq_enable,
  input  logic                   irq_ack,
  input  logic                   irq_done,
  input  logic                   overrun_clear,
  output logic                   irq_out,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [OVR_CNT_W-1:0]   overrun_count,
  output logic                   overrun_flag
);

  irq_state_e             state_r;
  irq_state_e             next_state_s;
  logic                   ovr_event_s;
  logic                   irq_out_r;
  logic                   busy_r;
  logic                   overrun_flag_r;
  logic [FRAME_CNT_W-1:0] frame_count_r;

  // Next-state and overrun detection; a frame arriving while one is still
  // outstanding is dropped and leaves the state untouched.
  always_comb begin
    next_state_s = state_r;
    ovr_event_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (interrupt_in && irq_enable) begin
          next_state_s = PENDING;
        end else begin
          next_state_s = IDLE;
        end
      end
      PENDING: begin
        ovr_event_s = interrupt_in;
        if (irq_ack) begin
          next_state_s = SERVICE;
        end else begin
          next_state_s = PENDING;
        end
      end
      SERVICE: begin
        if (irq_done) begin
          if (interrupt_in && irq_enable) begin
            next_state_s = PENDING;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          ovr_event_s  = interrupt_in;
          next_state_s = SERVICE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, registered handshake outputs, frame counter and sticky overrun flag.
  always_ff @(posedge pixel_clock) begin
    if (rst) begin
      state_r        <= IDLE;
      irq_out_r      <= 1'b0;
      busy_r         <= 1'b0;
      frame_count_r  <= {FRAME_CNT_W{1'b0}};
      overrun_flag_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      irq_out_r <= (next_state_s == PENDING);
      busy_r    <= (next_state_s == SERVICE);
      if (interrupt_in) begin
        frame_count_r <= frame_count_r + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
      end
      if (ovr_event_s) begin
        overrun_flag_r <= 1'b1;
      end else if (overrun_clear) begin
        overrun_flag_r <= 1'b0;
      end
    end
  end

  sat_counter #(
    .W (OVR_CNT_W)
  ) u_ovr_cnt (
    .clk   (pixel_clock),
    .rst   (rst),
    .inc   (ovr_event_s),
    .clr   (overrun_clear),
    .count (overrun_count)
  );

  assign irq_out      = irq_out_r;
  assign busy         = busy_r;
  assign frame_count  = frame_count_r;
  assign overrun_flag = overrun_flag_r;

endmodule

// File: tb/tb_vga_irq_handler.sv
// Bench for vga_irq_handler: directed scenarios with literal expectations plus
// a randomized run checked every cycle against a behavioural model.
module tb_vga_irq_handler;

  logic        pixel_clock = 1'b0;
  logic        rst = 1'b1;
  logic        interrupt_in = 1'b0;
  logic        irq_enable = 1'b0;
  logic        irq_ack = 1'b0;
  logic        irq_done = 1'b0;
  logic        overrun_clear = 1'b0;
  logic        irq_out;
  logic        busy;
  logic [15:0] frame_count;
  logic [7:0]  overrun_count;
  logic        overrun_flag;

  int checks = 0;
  int errors = 0;

  // Behavioural model: "waiting" = IRQ raised and not yet acknowledged,
  // "serving" = acknowledged and not yet done.
  bit waiting = 1'b0;
  bit serving = 1'b0;
  int m_frames = 0;
  int m_ovr = 0;
  bit m_flag = 1'b0;
  bit model_valid = 1'b0;

  vga_irq_handler dut (
    .pixel_clock   (pixel_clock),
    .rst           (rst),
    .interrupt_in  (interrupt_in),
    .irq_enable    (irq_enable),
    .irq_ack       (irq_ack),
    .irq_done      (irq_done),
    .overrun_clear (overrun_clear),
    .irq_out       (irq_out),
    .busy          (busy),
    .frame_count   (frame_count),
    .overrun_count (overrun_count),
    .overrun_flag  (overrun_flag)
  );

  always #5 pixel_clock = ~pixel_clock;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the inputs present at each rising edge.
  always @(posedge pixel_clock) begin
    bit dropped;
    if (rst) begin
      waiting = 1'b0; serving = 1'b0;
      m_frames = 0; m_ovr = 0; m_flag = 1'b0;
      model_valid = 1'b1;
    end else begin
      if (interrupt_in) m_frames = (m_frames + 1) % 65536;
      dropped = interrupt_in && (waiting || (serving && !irq_done));
      if (dropped) begin
        m_flag = 1'b1;
        m_ovr  = overrun_clear ? 1 : ((m_ovr < 255) ? m_ovr + 1 : 255);
      end else if (overrun_clear) begin
        m_flag = 1'b0;
        m_ovr  = 0;
      end
      if (waiting) begin
        if (irq_ack) begin waiting = 1'b0; serving = 1'b1; end
      end else if (serving) begin
        if (irq_done) begin
          serving = 1'b0;
          waiting = interrupt_in && irq_enable;
        end
      end else begin
        waiting = interrupt_in && irq_enable;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge pixel_clock) begin
    if (model_valid) begin
      chk("irq_out",       irq_out,       waiting);
      chk("busy",          busy,          serving);
      chk("frame_count",   frame_count,   m_frames);
      chk("overrun_count", overrun_count, m_ovr);
      chk("overrun_flag",  overrun_flag,  m_flag);
    end
  end

  task automatic step(input bit i, input bit en, input bit a, input bit d,
                      input bit c, input bit r);
    interrupt_in = i; irq_enable = en; irq_ack = a; irq_done = d;
    overrun_clear = c; rst = r;
    @(posedge pixel_clock);
    #1;
    interrupt_in = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
    overrun_clear = 1'b0; rst = 1'b0;
  endtask

  initial begin
    int hi;
    int bz;

    // Reset values
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_irq", irq_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames", frame_count, 0);
    chk("rst_ovr", overrun_count, 0);
    chk("rst_flag", overrun_flag, 0);

    // First pulse: irq one cycle later
    step(0, 1, 0, 0, 0, 0);
    chk("pre_irq", irq_out, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("lat1_irq", irq_out, 1);
    chk("lat1_frames", frame_count, 1);
    chk("lat1_busy", busy, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);

    // Ack three cycles after pulse, done ten after ack
    step(1, 1, 0, 0, 0, 0);
    hi = 0;
    for (int k = 0; k < 3; k++) begin
      if (irq_out) hi++;
      step(0, 1, (k == 2), 0, 0, 0);
    end
    chk("irq_hi_cycles", hi, 3);
    bz = 0;
    for (int k = 0; k < 10; k++) begin
      if (busy) bz++;
      step(0, 1, 0, (k == 9), 0, 0);
    end
    chk("busy_cycles", bz, 10);
    chk("svc_idle_irq", irq_out, 0);
    chk("svc_idle_busy", busy, 0);
    chk("svc_ovr", overrun_count, 0);

    // Overrun in PENDING and in SERVICE
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("ovr_pend_irq", irq_out, 1);
    step(0, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("ovr_svc_busy", busy, 1);
    chk("ovr_count2", overrun_count, 2);
    chk("ovr_flag", overrun_flag, 1);
    chk("ovr_frames", frame_count, 5);
    step(0, 1, 0, 1, 0, 0);

    // Done coinciding with a pulse, enabled then disabled
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    chk("done_pulse_en_irq", irq_out, 1);
    chk("done_pulse_en_ovr", overrun_count, 2);
    step(0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("done_pulse_dis_irq", irq_out, 0);
    chk("done_pulse_dis_busy", busy, 0);
    chk("done_pulse_dis_ovr", overrun_count, 2);

    // Saturation, then clear colliding with an overrun
    step(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 300; k++) step(1, 1, 0, 0, 0, 0);
    chk("sat_count", overrun_count, 255);
    step(1, 1, 0, 0, 1, 0);
    chk("clr_vs_ovr_count", overrun_count, 1);
    chk("clr_vs_ovr_flag", overrun_flag, 1);
    step(0, 1, 0, 0, 1, 0);
    chk("clr_count", overrun_count, 0);
    chk("clr_flag", overrun_flag, 0);

    // Reset mid-service
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 1, 0, 0, 0, 0);
    chk("mid_busy", busy, 1);
    chk("mid_frames", frame_count, 5);
    step(0, 1, 0, 0, 0, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_irq", irq_out, 0);
    chk("midrst_frames", frame_count, 0);
    chk("midrst_ovr", overrun_count, 0);
    chk("midrst_flag", overrun_flag, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("dis_frames", frame_count, 1);
    chk("dis_irq", irq_out, 0);

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 30) == 0), ($urandom_range(0, 400) == 0));
    end

    @(negedge pixel_clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_irq_handler.md
Name: vga_irq_handler

Overview:
Consumer end of the end-of-frame interrupt pulse produced by the VGA timing path. The pulse is one `pixel_clock` cycle wide.
- Converts the pulse into a level IRQ that game logic (physics/scroll update) services with an ack/done handshake.
- Counts frames and detects overruns, i.e. frames that arrive while a previous frame is still unserviced.
- Sits between the VGA interrupt source and the game-state update logic, all in the `pixel_clock` domain.

Parameters:
- FRAME_CNT_W, 16, width of the free-running frame counter.
- OVR_CNT_W, 8, width of the saturating overrun counter.

Ports:
- pixel_clock  input  1  sole clock.
- rst  input  1  reset. Synchronous to pixel_clock, active-high.
- interrupt_in  input  1  one-cycle end-of-frame pulse.
- irq_enable  input  1  when low, new pulses do not raise the IRQ.
- irq_ack  input  1  consumer has seen the IRQ and starts servicing.
- irq_done  input  1  consumer has finished the frame update.
- overrun_clear  input  1  clears overrun_flag and overrun_count.
- irq_out  output  1  level IRQ. High only in state PENDING.
- busy  output  1  high only in state SERVICE.
- frame_count  output  FRAME_CNT_W  number of interrupt_in pulses seen. Wraps.
- overrun_count  output  OVR_CNT_W  number of overrun events. Saturates at all-ones.
- overrun_flag  output  1  sticky; set on any overrun.

Behaviour:
- All outputs are registered. After rst: state IDLE, irq_out=0, busy=0, frame_count=0, overrun_count=0, overrun_flag=0.
- rst asserted in any state returns everything to the reset values on the next edge, even mid-service.
- frame_count increments on every interrupt_in pulse, independent of state and irq_enable. It wraps from all-ones to 0.
- FSM states: IDLE, PENDING, SERVICE.
- IDLE:
  - interrupt_in && irq_enable -> PENDING. irq_out goes high the cycle after the pulse (latency 1).
  - interrupt_in && !irq_enable -> stay IDLE. The frame is counted; it is not an overrun.
  - irq_ack and irq_done are ignored.
- PENDING:
  - irq_ack -> SERVICE (irq_out=0, busy=1 next cycle).
  - irq_done without irq_ack is ignored.
  - irq_ack && irq_done in the same cycle: treated as ack only -> SERVICE.
  - irq_enable falling while in PENDING does not withdraw the IRQ.
- SERVICE:
  - irq_done && !interrupt_in -> IDLE.
  - irq_done && interrupt_in -> PENDING if irq_enable, else IDLE. Not an overrun.
  - irq_ack is ignored.
- Overrun: interrupt_in in PENDING, or in SERVICE without simultaneous irq_done, counts as one overrun.
  - overrun_flag is set.
  - overrun_count increments, holding at 2^OVR_CNT_W-1.
  - The state is unchanged; the new frame is dropped, never queued.
- overrun_clear: the next cycle has overrun_flag=0 and overrun_count=0.
- overrun_clear in the same cycle as an overrun event: the overrun wins, giving flag=1 and count=1.

Decomposition:
- Shared package `vga_pkg` holds:
  - state encoding constants: IDLE=2'd0, PENDING=2'd1, SERVICE=2'd2;
  - the default widths FRAME_CNT_W and OVR_CNT_W;
  - the VGA_WIDTH/VGA_HEIGHT constants already used by the timing path.
- One sub-module: `sat_counter` (parameterized width, inc/clr inputs, saturating; clr-then-inc in the same cycle yields 1). It is used for overrun_count.

Test Plan:
- Reset, then a pulse with irq_enable=1 -> irq_out=1 exactly one cycle after the pulse; frame_count=1; busy=0.
- Pulse, ack 3 cycles later, done 10 cycles after that -> irq_out high 3 cycles; busy high 10 cycles; back to IDLE; overrun_count=0.
- Second pulse while in PENDING, then a third while in SERVICE -> overrun_count=2, overrun_flag=1, state path unchanged, frame_count=3.
- irq_done and interrupt_in in the same cycle in SERVICE with irq_enable=1 -> next cycle PENDING, irq_out=1, overrun_count unchanged.
- Repeat for irq_done and interrupt_in with irq_enable=0 -> next cycle IDLE, irq_out=0, overrun_count unchanged.
- Force 300 overruns with OVR_CNT_W=8 -> overrun_count=255.
- Then overrun_clear coinciding with an overrun -> count=1, flag=1.
- Assert rst while in SERVICE with frame_count=5 -> next cycle all outputs are 0 and the state is IDLE.
- Then a pulse with irq_enable=0 -> frame_count=1, irq_out stays 0.
